// File: rtl/mem_arbiter_pkg.sv
// Shared widths, response codes and FSM state type for the fetch/data memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned MEM_CODE_W     = 2;
    localparam int unsigned MEM_COUNT_W    = 2;

    localparam logic [MEM_CODE_W-1:0] MEM_CODE_OK      = 2'd0;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_ERR     = 2'd1;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_TIMEOUT = 2'd2;

    // Instruction fetches are always full 4-byte reads.
    localparam logic [MEM_COUNT_W-1:0] FETCH_COUNT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_FE  = 2'd1,
        ST_BUSY_MEM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle counter: cleared while idle, counts while a transaction is outstanding,
// flags expiry on the last allowed cycle.
module mem_arb_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] r_count;

    assign o_expire = (r_count == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory bus between instruction fetch and data access.
// Data wins ties; a streak limit guarantees fetch progress; timeouts and stray responses are flagged.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_fe_req,
    input  logic [ADDR_W-1:0]      i_fe_addr,
    input  logic                   i_fe_flush,
    output logic                   o_fe_gnt,
    output logic                   o_fe_rvalid,
    output logic [DATA_W-1:0]      o_fe_rdata,
    input  logic                   i_mem_req,
    input  logic [ADDR_W-1:0]      i_mem_addr,
    input  logic [DATA_W-1:0]      i_mem_wr_data,
    input  logic                   i_mem_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_mem_count,
    output logic                   o_mem_gnt,
    output logic                   o_mem_rvalid,
    output logic [DATA_W-1:0]      o_mem_rdata,
    output logic [MEM_CODE_W-1:0]  o_mem_code,
    output logic                   o_bus_req,
    output logic [ADDR_W-1:0]      o_bus_addr,
    output logic [DATA_W-1:0]      o_bus_wr_data,
    output logic                   o_bus_wr_en,
    output logic [MEM_COUNT_W-1:0] o_bus_count,
    input  logic                   i_bus_ready,
    input  logic                   i_bus_rvalid,
    input  logic [DATA_W-1:0]      i_bus_rdata,
    input  logic [MEM_CODE_W-1:0]  i_bus_code,
    output logic                   o_err_sticky
);

    localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [STREAK_W-1:0]   r_streak;
    logic                  r_kill;
    logic                  r_is_wr;
    logic                  r_fe_rvalid;
    logic [DATA_W-1:0]     r_fe_rdata;
    logic                  r_mem_rvalid;
    logic [DATA_W-1:0]     r_mem_rdata;
    logic [MEM_CODE_W-1:0] r_mem_code;
    logic                  r_err_sticky;

    logic w_pick_fe;
    logic w_fe_gnt;
    logic w_mem_gnt;
    logic w_rsp;
    logic w_timeout;
    logic w_expire;
    logic w_stray;

    mem_arb_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (r_state == ST_IDLE),
        .i_enable (r_state != ST_IDLE),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration, bus request mux and transaction completion.
    always_comb begin
        w_state_nxt   = r_state;
        w_pick_fe     = 1'b0;
        w_fe_gnt      = 1'b0;
        w_mem_gnt     = 1'b0;
        w_rsp         = 1'b0;
        w_timeout     = 1'b0;
        o_bus_req     = 1'b0;
        o_bus_addr    = '0;
        o_bus_wr_data = '0;
        o_bus_wr_en   = 1'b0;
        o_bus_count   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_fe_req || i_mem_req) begin
                    o_bus_req = 1'b1;
                    w_pick_fe = i_fe_req &&
                                (!i_mem_req || (r_streak == STREAK_W'(MAX_STREAK)));
                    if (w_pick_fe) begin
                        o_bus_addr  = i_fe_addr;
                        o_bus_count = FETCH_COUNT;
                        w_fe_gnt    = i_bus_ready;
                        if (i_bus_ready) begin
                            w_state_nxt = ST_BUSY_FE;
                        end
                    end else begin
                        o_bus_addr    = i_mem_addr;
                        o_bus_wr_data = i_mem_wr_data;
                        o_bus_wr_en   = i_mem_wr_en;
                        o_bus_count   = i_mem_count;
                        w_mem_gnt     = i_bus_ready;
                        if (i_bus_ready) begin
                            w_state_nxt = ST_BUSY_MEM;
                        end
                    end
                end
            end
            ST_BUSY_FE, ST_BUSY_MEM: begin
                if (i_bus_rvalid) begin
                    w_rsp       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_expire) begin
                    w_rsp       = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_fe_gnt  = w_fe_gnt;
    assign o_mem_gnt = w_mem_gnt;
    assign w_stray   = (r_state == ST_IDLE) && i_bus_rvalid;

    // Starvation guard: count data grants that bypassed a waiting fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_streak <= '0;
        end else if (w_fe_gnt) begin
            r_streak <= '0;
        end else if (w_mem_gnt && i_fe_req && (r_streak != STREAK_W'(MAX_STREAK))) begin
            r_streak <= r_streak + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kill  <= 1'b0;
            r_is_wr <= 1'b0;
        end else begin
            if (w_mem_gnt) begin
                r_is_wr <= i_mem_wr_en;
            end
            if ((r_state == ST_BUSY_FE) && (w_state_nxt != ST_BUSY_FE)) begin
                r_kill <= 1'b0;
            end else if (i_fe_flush && (w_fe_gnt || (r_state == ST_BUSY_FE))) begin
                r_kill <= 1'b1;
            end
        end
    end

    // Registered per-requester responses; a flushed fetch completes silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fe_rvalid  <= 1'b0;
            r_fe_rdata   <= '0;
            r_mem_rvalid <= 1'b0;
            r_mem_rdata  <= '0;
            r_mem_code   <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            r_fe_rvalid  <= 1'b0;
            r_mem_rvalid <= 1'b0;
            if (w_rsp && (r_state == ST_BUSY_FE) && !r_kill && !i_fe_flush) begin
                r_fe_rvalid <= 1'b1;
                r_fe_rdata  <= w_timeout ? '0 : i_bus_rdata;
            end
            if (w_rsp && (r_state == ST_BUSY_MEM)) begin
                r_mem_rvalid <= 1'b1;
                r_mem_rdata  <= (w_timeout || r_is_wr) ? '0 : i_bus_rdata;
                r_mem_code   <= w_timeout ? MEM_CODE_TIMEOUT : i_bus_code;
            end
            if (w_timeout || w_stray) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

    assign o_fe_rvalid  = r_fe_rvalid;
    assign o_fe_rdata   = r_fe_rdata;
    assign o_mem_rvalid = r_mem_rvalid;
    assign o_mem_rdata  = r_mem_rdata;
    assign o_mem_code   = r_mem_code;
    assign o_err_sticky = r_err_sticky;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MS = 4;
    localparam int unsigned TO = 255;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   i_fe_req = 1'b0;
    logic [AW-1:0]          i_fe_addr = '0;
    logic                   i_fe_flush = 1'b0;
    logic                   o_fe_gnt;
    logic                   o_fe_rvalid;
    logic [DW-1:0]          o_fe_rdata;
    logic                   i_mem_req = 1'b0;
    logic [AW-1:0]          i_mem_addr = '0;
    logic [DW-1:0]          i_mem_wr_data = '0;
    logic                   i_mem_wr_en = 1'b0;
    logic [MEM_COUNT_W-1:0] i_mem_count = '0;
    logic                   o_mem_gnt;
    logic                   o_mem_rvalid;
    logic [DW-1:0]          o_mem_rdata;
    logic [MEM_CODE_W-1:0]  o_mem_code;
    logic                   o_bus_req;
    logic [AW-1:0]          o_bus_addr;
    logic [DW-1:0]          o_bus_wr_data;
    logic                   o_bus_wr_en;
    logic [MEM_COUNT_W-1:0] o_bus_count;
    logic                   i_bus_ready = 1'b0;
    logic                   i_bus_rvalid = 1'b0;
    logic [DW-1:0]          i_bus_rdata = '0;
    logic [MEM_CODE_W-1:0]  i_bus_code = '0;
    logic                   o_err_sticky;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MS), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .i_fe_req(i_fe_req), .i_fe_addr(i_fe_addr), .i_fe_flush(i_fe_flush),
        .o_fe_gnt(o_fe_gnt), .o_fe_rvalid(o_fe_rvalid), .o_fe_rdata(o_fe_rdata),
        .i_mem_req(i_mem_req), .i_mem_addr(i_mem_addr), .i_mem_wr_data(i_mem_wr_data),
        .i_mem_wr_en(i_mem_wr_en), .i_mem_count(i_mem_count),
        .o_mem_gnt(o_mem_gnt), .o_mem_rvalid(o_mem_rvalid), .o_mem_rdata(o_mem_rdata),
        .o_mem_code(o_mem_code),
        .o_bus_req(o_bus_req), .o_bus_addr(o_bus_addr), .o_bus_wr_data(o_bus_wr_data),
        .o_bus_wr_en(o_bus_wr_en), .o_bus_count(o_bus_count),
        .i_bus_ready(i_bus_ready), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata),
        .i_bus_code(i_bus_code), .o_err_sticky(o_err_sticky)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner 0=none 1=fetch 2=data; wait = busy cycles already spent.
    int                    m_owner, m_wait, m_streak;
    bit                    m_kill, m_wr, m_sticky, m_fe_rv, m_mem_rv, m_gnt_fe, m_gnt_mem;
    logic [DW-1:0]         m_fe_rd, m_mem_rd;
    logic [MEM_CODE_W-1:0] m_code;

    task automatic model_reset();
        m_owner = 0; m_wait = 0; m_streak = 0;
        m_kill = 0; m_wr = 0; m_sticky = 0; m_fe_rv = 0; m_mem_rv = 0;
        m_gnt_fe = 0; m_gnt_mem = 0;
        m_fe_rd = '0; m_mem_rd = '0; m_code = '0;
    endtask

    // Called just after a negedge with inputs applied; checks, advances model, returns at next negedge.
    task automatic tick();
        bit want, pick_fe, tmo;
        #1;
        want     = (m_owner == 0) && (i_fe_req || i_mem_req);
        pick_fe  = i_fe_req && (!i_mem_req || (m_streak >= MS));
        m_gnt_fe  = want && pick_fe && i_bus_ready;
        m_gnt_mem = want && !pick_fe && i_bus_ready;
        chk("bus_req", o_bus_req, want);
        chk("fe_gnt", o_fe_gnt, m_gnt_fe);
        chk("mem_gnt", o_mem_gnt, m_gnt_mem);
        if (want && pick_fe) begin
            chk("bus_addr_fe", o_bus_addr, i_fe_addr);
            chk("bus_wr_en_fe", o_bus_wr_en, 0);
            chk("bus_count_fe", o_bus_count, 3);
        end else if (want) begin
            chk("bus_addr_mem", o_bus_addr, i_mem_addr);
            chk("bus_wr_en_mem", o_bus_wr_en, i_mem_wr_en);
            chk("bus_count_mem", o_bus_count, i_mem_count);
            chk("bus_wr_data", o_bus_wr_data, i_mem_wr_data);
        end
        chk("fe_rvalid", o_fe_rvalid, m_fe_rv);
        chk("mem_rvalid", o_mem_rvalid, m_mem_rv);
        chk("err_sticky", o_err_sticky, m_sticky);
        if (m_fe_rv) chk("fe_rdata", o_fe_rdata, m_fe_rd);
        if (m_mem_rv) begin
            chk("mem_rdata", o_mem_rdata, m_mem_rd);
            chk("mem_code", o_mem_code, m_code);
        end
        m_fe_rv = 0; m_mem_rv = 0;
        if (m_owner == 0) begin
            if (i_bus_rvalid) m_sticky = 1;
            if (m_gnt_fe) begin
                m_owner = 1; m_wait = 0; m_kill = i_fe_flush; m_streak = 0;
            end else if (m_gnt_mem) begin
                m_owner = 2; m_wait = 0; m_wr = i_mem_wr_en; m_kill = 0;
                if (i_fe_req && m_streak < MS) m_streak++;
            end
        end else begin
            tmo = !i_bus_rvalid && (m_wait == TO - 1);
            if (i_bus_rvalid || tmo) begin
                if (m_owner == 1 && !m_kill && !i_fe_flush) begin
                    m_fe_rv = 1;
                    m_fe_rd = tmo ? '0 : i_bus_rdata;
                end
                if (m_owner == 2) begin
                    m_mem_rv = 1;
                    m_mem_rd = (tmo || m_wr) ? '0 : i_bus_rdata;
                    m_code   = tmo ? MEM_CODE_TIMEOUT : i_bus_code;
                end
                if (tmo) m_sticky = 1;
                m_owner = 0; m_kill = 0;
            end else begin
                m_wait++;
                if (m_owner == 1 && i_fe_flush) m_kill = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_fe_req = 0; i_fe_flush = 0; i_mem_req = 0; i_mem_wr_en = 0;
        i_bus_ready = 0; i_bus_rvalid = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && m_owner != 0; k++) begin
            i_bus_rvalid = 1'b1;
            tick();
        end
        i_bus_rvalid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int mem_run, fe_seen, cd;
        bit fe_pend, mem_pend;
        model_reset();
        @(negedge clk);
        do_reset();
        tick();

        // Fetch read of 0x100 answered three cycles after the grant.
        i_fe_req = 1; i_fe_addr = 32'h100; i_bus_ready = 1;
        tick();
        i_fe_req = 0;
        tick(); tick();
        i_bus_rvalid = 1; i_bus_rdata = 32'hDEADBEEF; i_bus_code = MEM_CODE_OK;
        tick();
        i_bus_rvalid = 0;
        tick(); tick();

        // Both requesting: four data grants, then fetch; repeated to show the streak restarts.
        i_mem_addr = 32'h400; i_mem_count = 2'd1;
        for (int r = 0; r < 2; r++) begin
            mem_run = 0; fe_seen = 0;
            i_fe_req = 1; i_mem_req = 1;
            for (int k = 0; k < 14 && fe_seen == 0; k++) begin
                i_bus_rvalid = (m_owner != 0);
                #1;
                if (o_fe_gnt) fe_seen = 1;
                else if (o_mem_gnt) mem_run++;
                tick();
            end
            chk("streak_run", mem_run, MS);
            chk("fe_after_streak", fe_seen, 1);
        end
        i_fe_req = 0; i_mem_req = 0;
        drain();

        // Flushed fetch completes silently; the following data read is normal.
        i_fe_req = 1; i_fe_addr = 32'h180;
        tick();
        i_fe_req = 0; i_fe_flush = 1;
        tick();
        i_fe_flush = 0;
        tick();
        i_bus_rvalid = 1; i_bus_rdata = 32'h11112222;
        tick();
        i_bus_rvalid = 0; i_mem_req = 1; i_mem_wr_en = 0; i_mem_addr = 32'h300;
        tick();
        i_mem_req = 0; i_bus_rvalid = 1; i_bus_rdata = 32'h33334444; i_bus_code = MEM_CODE_ERR;
        tick();
        i_bus_rvalid = 0;
        tick();

        // Data read that is never answered times out.
        i_mem_req = 1; i_mem_addr = 32'h500;
        tick();
        i_mem_req = 0;
        repeat (TO + 2) tick();

        // Response on the very last cycle before timeout is taken as a normal response.
        i_mem_req = 1; i_mem_addr = 32'h504;
        tick();
        i_mem_req = 0;
        repeat (TO - 1) tick();
        i_bus_rvalid = 1; i_bus_rdata = 32'h55667788; i_bus_code = MEM_CODE_OK;
        tick();
        i_bus_rvalid = 0;
        tick();

        // Write 0xCAFE0000 to 0x200, acked with nonzero rdata that must not be forwarded.
        i_mem_req = 1; i_mem_wr_en = 1; i_mem_addr = 32'h200;
        i_mem_wr_data = 32'hCAFE0000; i_mem_count = 2'd3;
        tick();
        i_mem_req = 0;
        tick();
        i_bus_rvalid = 1; i_bus_rdata = 32'h12345678; i_bus_code = MEM_CODE_OK;
        tick();
        i_bus_rvalid = 0; i_mem_wr_en = 0;
        tick();

        // Reset during BUSY_MEM; the late response is a stray.
        i_mem_req = 1; i_mem_addr = 32'h600;
        tick();
        i_mem_req = 0;
        tick();
        do_reset();
        i_bus_ready = 1;
        tick();
        i_bus_rvalid = 1; i_bus_rdata = 32'h99999999;
        tick();
        i_bus_rvalid = 0;
        tick();

        // Randomized traffic.
        do_reset();
        fe_pend = 0; mem_pend = 0; cd = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!fe_pend && $urandom_range(0, 3) == 0) begin
                fe_pend = 1; i_fe_addr = $urandom;
            end
            if (!mem_pend && $urandom_range(0, 2) == 0) begin
                mem_pend = 1; i_mem_addr = $urandom; i_mem_wr_data = $urandom;
                i_mem_wr_en = 1'($urandom); i_mem_count = MEM_COUNT_W'($urandom);
            end
            i_fe_req    = fe_pend;
            i_mem_req   = mem_pend;
            i_bus_ready = ($urandom_range(0, 3) != 0);
            i_fe_flush  = ($urandom_range(0, 9) == 0);
            i_bus_rdata = $urandom;
            i_bus_code  = MEM_CODE_W'($urandom);
            if (cd > 0) begin
                cd--;
                i_bus_rvalid = (cd == 0);
            end else begin
                i_bus_rvalid = (m_owner == 0) && ($urandom_range(0, 199) == 0);
            end
            tick();
            if (m_gnt_fe) fe_pend = 0;
            if (m_gnt_mem) mem_pend = 0;
            if (m_gnt_fe || m_gnt_mem)
                cd = ($urandom_range(0, 49) == 0) ? -1 : int'($urandom_range(1, 6));
        end
        clear_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
